// File: rtl/therm_dec_8b.sv
// ============================================================================
// Module   : therm_dec_8b
// Brief    : Active-low 8-level thermometer decoder that ramps one level per
//            enabled clock towards a captured target code, with ready/busy/
//            done handshake. Optional one-hot output via THERM_DEC_ONEHOT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module therm_dec_8b (
    input  logic       clk,
    input  logic       rst_low,
    input  logic       En_low,
    input  logic [2:0] Y_low,
    input  logic       GS_low,
    output logic       Rdy_low,
    output logic [7:0] T_low,
    output logic       Done_low,
    output logic       Busy_low
`ifdef THERM_DEC_ONEHOT_EN
    ,
    output logic [7:0] O_low
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RAMP_UP   = 2'd1;
    localparam logic [1:0] S_RAMP_DOWN = 2'd2;
    localparam logic [2:0] C_LVL_MAX   = 3'd7;
    localparam logic [2:0] C_LVL_MIN   = 3'd0;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_lvl;
    logic [2:0] w_lvl_nxt;
    logic [2:0] r_tgt;
    logic [2:0] w_tgt_nxt;
    logic       r_act;
    logic       w_act_nxt;
    logic       r_done;
    logic       w_done_set;

    logic       w_en;
    logic [2:0] w_code;
    logic [2:0] w_lvl_inc;
    logic [2:0] w_lvl_dec;
    logic       w_show;

    assign w_en      = ~En_low;
    assign w_code    = ~Y_low;
    assign w_lvl_inc = r_lvl + 3'd1;
    assign w_lvl_dec = r_lvl - 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_lvl_nxt   = r_lvl;
        w_tgt_nxt   = r_tgt;
        w_act_nxt   = r_act;
        w_done_set  = 1'b0;
        if (w_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!GS_low) begin
                        w_tgt_nxt = w_code;
                        w_act_nxt = 1'b1;
                        // Level is 0 before the first accept, so equality
                        // also covers the first-accept-of-zero case.
                        if (w_code == r_lvl) begin
                            w_done_set = 1'b1;
                        end else if (w_code > r_lvl) begin
                            w_state_nxt = S_RAMP_UP;
                        end else begin
                            w_state_nxt = S_RAMP_DOWN;
                        end
                    end
                end
                S_RAMP_UP: begin
                    if (r_lvl == C_LVL_MAX) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_lvl_nxt = w_lvl_inc;
                        if (w_lvl_inc == r_tgt) begin
                            w_state_nxt = S_IDLE;
                            w_done_set  = 1'b1;
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (r_lvl == C_LVL_MIN) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_lvl_nxt = w_lvl_dec;
                        if (w_lvl_dec == r_tgt) begin
                            w_state_nxt = S_IDLE;
                            w_done_set  = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_low) begin
        if (!rst_low) begin
            r_state <= S_IDLE;
            r_lvl   <= 3'd0;
            r_tgt   <= 3'd0;
            r_act   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lvl   <= w_lvl_nxt;
            r_tgt   <= w_tgt_nxt;
            r_act   <= w_act_nxt;
            // A pending pulse is held through disabled cycles and retires
            // only after it has been visible for one enabled cycle.
            r_done  <= w_done_set | (r_done & En_low);
        end
    end

    assign w_show   = r_act & w_en;
    assign Rdy_low  = ~((r_state == S_IDLE) & w_en);
    assign Busy_low = ~((r_state != S_IDLE) & w_en);
    assign Done_low = ~(r_done & w_en);

    for (genvar n = 0; n < 8; n++) begin : g_therm
        localparam logic [2:0] C_N = 3'(n);
        assign T_low[n] = ~(w_show & (C_N <= r_lvl));
    end

`ifdef THERM_DEC_ONEHOT_EN
    for (genvar n = 0; n < 8; n++) begin : g_onehot
        localparam logic [2:0] C_N = 3'(n);
        assign O_low[n] = ~(w_show & (C_N == r_lvl));
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_therm_dec_8b.sv
// ============================================================================
// Module   : tb_therm_dec_8b
// Brief    : Directed self-checking bench for therm_dec_8b.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_therm_dec_8b;

    logic       clk;
    logic       rst_low;
    logic       En_low;
    logic [2:0] Y_low;
    logic       GS_low;
    logic       Rdy_low;
    logic [7:0] T_low;
    logic       Done_low;
    logic       Busy_low;
`ifdef THERM_DEC_ONEHOT_EN
    logic [7:0] O_low;
`endif

    int n_total;
    int n_bad;

    therm_dec_8b u_dut (
        .clk      (clk),
        .rst_low  (rst_low),
        .En_low   (En_low),
        .Y_low    (Y_low),
        .GS_low   (GS_low),
        .Rdy_low  (Rdy_low),
        .T_low    (T_low),
        .Done_low (Done_low),
        .Busy_low (Busy_low)
`ifdef THERM_DEC_ONEHOT_EN
        ,
        .O_low    (O_low)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] up_exp   [7];
    logic [7:0] down_exp [5];

    initial begin
        n_total = 0;
        n_bad   = 0;
        up_exp   = '{8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        down_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8};

        rst_low = 1'b0;
        En_low  = 1'b0;
        GS_low  = 1'b1;
        Y_low   = 3'b111;
        tick();
        tick();
        check("rst_T", T_low, 8'hFF);
        check("rst_rdy", {7'd0, Rdy_low}, 8'd0);
        check("rst_done", {7'd0, Done_low}, 8'd1);
        check("rst_busy", {7'd0, Busy_low}, 8'd1);
        rst_low = 1'b1;
        tick();
        check("idle_T", T_low, 8'hFF);
        check("idle_rdy", {7'd0, Rdy_low}, 8'd0);

        // Ramp up 0 -> 7
        GS_low = 1'b0; Y_low = 3'b000;
        tick();
        GS_low = 1'b1;
        check("up_acc_T", T_low, 8'hFE);
        check("up_acc_busy", {7'd0, Busy_low}, 8'd0);
        check("up_acc_rdy", {7'd0, Rdy_low}, 8'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("up_T", T_low, up_exp[i]);
            check("up_done", {7'd0, Done_low}, (i == 6) ? 8'd0 : 8'd1);
        end
        check("up_end_busy", {7'd0, Busy_low}, 8'd1);
        tick();
        check("up_post_done", {7'd0, Done_low}, 8'd1);
        check("up_post_rdy", {7'd0, Rdy_low}, 8'd0);
        check("up_post_T", T_low, 8'h00);

        // Ramp down 7 -> 2 with a mid-ramp request that must be dropped
        GS_low = 1'b0; Y_low = 3'b101;
        tick();
        check("dn_acc_T", T_low, 8'h00);
        check("dn_acc_busy", {7'd0, Busy_low}, 8'd0);
        Y_low = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) GS_low = 1'b1;
            check("dn_T", T_low, down_exp[i]);
            check("dn_done", {7'd0, Done_low}, (i == 4) ? 8'd0 : 8'd1);
        end
        tick();
        check("dn_post_done", {7'd0, Done_low}, 8'd1);
        check("dn_post_T", T_low, 8'hF8);

        // Same-level request: immediate done, no busy
        GS_low = 1'b0; Y_low = 3'b101;
        tick();
        GS_low = 1'b1;
        check("eq_T", T_low, 8'hF8);
        check("eq_busy", {7'd0, Busy_low}, 8'd1);
        check("eq_done", {7'd0, Done_low}, 8'd0);
        tick();
        check("eq_post_done", {7'd0, Done_low}, 8'd1);

        // Down to 0 at the lower bound
        GS_low = 1'b0; Y_low = 3'b111;
        tick();
        GS_low = 1'b1;
        tick();
        check("z_T1", T_low, 8'hFC);
        tick();
        check("z_T0", T_low, 8'hFE);
        check("z_done", {7'd0, Done_low}, 8'd0);
        tick();

        // Ramp 0 -> 6 with a 3-cycle disable at level 3
        GS_low = 1'b0; Y_low = 3'b001;
        tick();
        GS_low = 1'b1;
        tick();
        tick();
        tick();
        check("fr_T3", T_low, 8'hF0);
        En_low = 1'b1;
        #1;
        check("fr_blank_T", T_low, 8'hFF);
        check("fr_blank_rdy", {7'd0, Rdy_low}, 8'd1);
        check("fr_blank_busy", {7'd0, Busy_low}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fr_hold_T", T_low, 8'hFF);
        end
        En_low = 1'b0;
        #1;
        check("fr_resume_T", T_low, 8'hF0);
        check("fr_resume_busy", {7'd0, Busy_low}, 8'd0);
        tick();
        check("fr_T4", T_low, 8'hE0);
        check("fr_done4", {7'd0, Done_low}, 8'd1);
        tick();
        check("fr_T5", T_low, 8'hC0);
        tick();
        check("fr_T6", T_low, 8'h80);
        check("fr_done6", {7'd0, Done_low}, 8'd0);
        tick();
        check("fr_post_done", {7'd0, Done_low}, 8'd1);

        // Done pulse falling due while disabled is deferred
        GS_low = 1'b0; Y_low = 3'b010;
        tick();
        GS_low = 1'b1;
        tick();
        En_low = 1'b1;
        #1;
        check("df_blank_done", {7'd0, Done_low}, 8'd1);
        tick();
        tick();
        check("df_hold_done", {7'd0, Done_low}, 8'd1);
        En_low = 1'b0;
        #1;
        check("df_done", {7'd0, Done_low}, 8'd0);
        check("df_T", T_low, 8'hC0);
`ifdef THERM_DEC_ONEHOT_EN
        check("df_onehot", O_low, 8'hDF);
`endif
        tick();
        check("df_post_done", {7'd0, Done_low}, 8'd1);

        // Reset mid-ramp at level 4
        GS_low = 1'b0; Y_low = 3'b111;
        tick();
        GS_low = 1'b1;
        tick();
        check("ar_T4", T_low, 8'hE0);
        rst_low = 1'b0;
        #1;
        check("ar_T", T_low, 8'hFF);
        check("ar_done", {7'd0, Done_low}, 8'd1);
        check("ar_busy", {7'd0, Busy_low}, 8'd1);
        check("ar_rdy", {7'd0, Rdy_low}, 8'd0);
        tick();
        tick();
        rst_low = 1'b1;
        tick();
        check("ar_post_T", T_low, 8'hFF);
        check("ar_post_done", {7'd0, Done_low}, 8'd1);
        check("ar_post_busy", {7'd0, Busy_low}, 8'd1);

        // First accept with target 0 after reset
        GS_low = 1'b0; Y_low = 3'b111;
        tick();
        GS_low = 1'b1;
        check("f0_T", T_low, 8'hFE);
        check("f0_done", {7'd0, Done_low}, 8'd0);
        check("f0_busy", {7'd0, Busy_low}, 8'd1);
        tick();
        check("f0_post_done", {7'd0, Done_low}, 8'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
